// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: 2-FF synchroniser, per-key debounce FSM,
// and registered level / press / release / long-press outputs.
module key_debounce #(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_CYC + 1);

  // The first synchronised sample is counted on the IDLE/HELD transition, so the
  // check states accept after DEBOUNCE_CYC-1 further matching samples.
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYC - 2);
  localparam logic [HW-1:0] HCNT_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HCNT_FIRE = HW'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] samp_q, samp_d;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    samp_d  = ~sync2_q;
  end

  // samp_q is a registered copy of s so the FSM and output flops line up with
  // the t0+2+DEBOUNCE_CYC latency while a DEBOUNCE_CYC-long excursion is still accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      samp_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_flag_q, long_flag_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          pressed;

    assign pressed = samp_q[i];

    always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_flag_d = long_flag_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;

      // Hold timer runs through release glitches; it saturates so it fires once.
      if (state_q == HELD || state_q == REL_CHK) begin
        if (hcnt_q != HCNT_MAX) begin
          hcnt_d = hcnt_q + HW'(1);
        end
        if (!long_flag_q && hcnt_q == HCNT_FIRE) begin
          long_d      = 1'b1;
          long_flag_d = 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_d = PRESS_CHK;
            dcnt_d  = '0;
          end
        end
        PRESS_CHK: begin
          if (!pressed) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d     = HELD;
            dcnt_d      = '0;
            hcnt_d      = '0;
            long_flag_d = 1'b0;
            level_d     = 1'b1;
            press_d     = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        HELD: begin
          if (!pressed) begin
            state_d = REL_CHK;
            dcnt_d  = '0;
          end
        end
        REL_CHK: begin
          if (pressed) begin
            state_d = HELD;
            dcnt_d  = '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d     = IDLE;
            dcnt_d      = '0;
            long_flag_d = 1'b0;
            long_d      = 1'b0;
            level_d     = 1'b0;
            release_d   = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q     <= IDLE;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        long_flag_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        hcnt_q      <= hcnt_d;
        long_flag_q <= long_flag_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
      end
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule
